// File: rtl/sprite_move_ctrl.sv
// Sprite position controller: tick-paced X then Y step, spawn load.
// Define SPRITE_WRAP_EN for wrap-around edges instead of clamping.
module sprite_move_ctrl #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 10,
    parameter int X_MAX  = 624,
    parameter int Y_MAX  = 464
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              tick,
    input  logic              dir_up,
    input  logic              dir_down,
    input  logic              dir_left,
    input  logic              dir_right,
    input  logic              spawn_req,
    input  logic [X_BITS-1:0] spawn_x,
    input  logic [Y_BITS-1:0] spawn_y,
    output logic              spawn_ack,
    output logic [X_BITS-1:0] x_pos,
    output logic [Y_BITS-1:0] y_pos,
    output logic              busy,
    output logic              tick_miss
);

    localparam logic [X_BITS-1:0] X_LIM = X_BITS'(X_MAX);
    localparam logic [Y_BITS-1:0] Y_LIM = Y_BITS'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [X_BITS-1:0] x_step, x_spawn;
    logic [Y_BITS-1:0] y_step, y_spawn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // spawn wins over a same-cycle tick; enable low mid-step aborts
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (spawn_req)            state_nxt = LOAD;
                else if (tick && enable)  state_nxt = STEP_X;
            end
            STEP_X:  state_nxt = enable ? STEP_Y : IDLE;
            STEP_Y:  state_nxt = IDLE;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        spawn_ack = (state == LOAD);
    end

    always_comb begin
        x_step = x_pos;
        if (dir_right && !dir_left) begin
            if (x_pos >= X_LIM) begin
`ifdef SPRITE_WRAP_EN
                x_step = '0;
`else
                x_step = X_LIM;
`endif
            end else begin
                x_step = x_pos + X_BITS'(1);
            end
        end else if (dir_left && !dir_right) begin
            if (x_pos == '0) begin
`ifdef SPRITE_WRAP_EN
                x_step = X_LIM;
`else
                x_step = '0;
`endif
            end else begin
                x_step = x_pos - X_BITS'(1);
            end
        end
    end

    always_comb begin
        y_step = y_pos;
        if (dir_down && !dir_up) begin
            if (y_pos >= Y_LIM) begin
`ifdef SPRITE_WRAP_EN
                y_step = '0;
`else
                y_step = Y_LIM;
`endif
            end else begin
                y_step = y_pos + Y_BITS'(1);
            end
        end else if (dir_up && !dir_down) begin
            if (y_pos == '0) begin
`ifdef SPRITE_WRAP_EN
                y_step = Y_LIM;
`else
                y_step = '0;
`endif
            end else begin
                y_step = y_pos - Y_BITS'(1);
            end
        end
    end

    always_comb begin
        x_spawn = (spawn_x > X_LIM) ? X_LIM : spawn_x;
        y_spawn = (spawn_y > Y_LIM) ? Y_LIM : spawn_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_pos     <= '0;
            y_pos     <= '0;
            tick_miss <= 1'b0;
        end else begin
            tick_miss <= tick && (state != IDLE);
            case (state)
                STEP_X: if (enable) x_pos <= x_step;
                STEP_Y: if (enable) y_pos <= y_step;
                LOAD: begin
                    x_pos <= x_spawn;
                    y_pos <= y_spawn;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Scoreboard bench for sprite_move_ctrl.
// Honours SPRITE_WRAP_EN the same way as the design.
module tb_sprite_move_ctrl;

    localparam int XB = 10;
    localparam int YB = 10;
    localparam int XM = 624;
    localparam int YM = 464;
`ifdef SPRITE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk, reset, enable, tick;
    logic          dir_up, dir_down, dir_left, dir_right;
    logic          spawn_req, spawn_ack, busy, tick_miss;
    logic [XB-1:0] spawn_x, x_pos;
    logic [YB-1:0] spawn_y, y_pos;

    sprite_move_ctrl #(
        .X_BITS(XB), .Y_BITS(YB), .X_MAX(XM), .Y_MAX(YM)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .dir_up(dir_up), .dir_down(dir_down),
        .dir_left(dir_left), .dir_right(dir_right),
        .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_ack(spawn_ack), .x_pos(x_pos), .y_pos(y_pos),
        .busy(busy), .tick_miss(tick_miss)
    );

    typedef struct {
        int x;
        int y;
    } pos_t;

    pos_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mx = 0;
    int   my = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int step(int p, logic inc, logic dec, int lim);
        if (inc && !dec) begin
            if (p >= lim) return WRAP ? 0 : lim;
            return p + 1;
        end
        if (dec && !inc) begin
            if (p == 0) return WRAP ? lim : 0;
            return p - 1;
        end
        return p;
    endfunction

    task automatic pop_cmp(input string tag);
        pos_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_x"}, int'(x_pos), e.x);
            check({tag, "_y"}, int'(y_pos), e.y);
            mx = e.x;
            my = e.y;
        end
    endtask

    task automatic set_dirs(input logic r, l, d, u);
        dir_right = r;
        dir_left  = l;
        dir_down  = d;
        dir_up    = u;
    endtask

    // called at a negedge with the FSM idle
    task automatic tick_step(input logic r, l, d, u);
        pos_t e;
        e.x = step(mx, r, l, XM);
        e.y = step(my, d, u, YM);
        exp_q.push_back(e);
        set_dirs(r, l, d, u);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("busy_stepx", int'(busy), 1);
        check("x_hold_stepx", int'(x_pos), mx);
        @(negedge clk);
        check("x_after_stepx", int'(x_pos), e.x);
        check("y_hold_stepy", int'(y_pos), my);
        @(negedge clk);
        check("busy_done", int'(busy), 0);
        pop_cmp("tick");
    endtask

    task automatic do_spawn(input int sx, input int sy);
        pos_t e;
        int   n;
        bit   got;
        e.x = (sx > XM) ? XM : sx;
        e.y = (sy > YM) ? YM : sy;
        exp_q.push_back(e);
        spawn_x   = XB'(sx);
        spawn_y   = YB'(sy);
        spawn_req = 1'b1;
        n   = 0;
        got = 1'b0;
        while (n < 8 && !got) begin
            @(negedge clk);
            n++;
            if (spawn_ack) got = 1'b1;
        end
        check("spawn_ack_seen", int'(got), 1);
        spawn_req = 1'b0;
        @(negedge clk);
        check("spawn_ack_low", int'(spawn_ack), 0);
        pop_cmp("spawn");
    endtask

    initial begin
        pos_t e;
        reset     = 1'b1;
        enable    = 1'b1;
        tick      = 1'b0;
        spawn_req = 1'b0;
        spawn_x   = '0;
        spawn_y   = '0;
        set_dirs(0, 0, 0, 0);
        @(negedge clk);
        check("rst_x", int'(x_pos), 0);
        check("rst_y", int'(y_pos), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(spawn_ack), 0);
        check("rst_miss", int'(tick_miss), 0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick_step(1, 0, 0, 0);
            check("r038_x", int'(x_pos), i + 1);
            check("r038_y", int'(y_pos), 0);
            repeat (7) @(negedge clk);
        end

        for (int i = 0; i < 4; i++) tick_step(1, 1, 0, 0);
        check("lr_hold", int'(x_pos), 3);

        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            check("dis_busy", int'(busy), 0);
            @(negedge clk);
            check("dis_miss", int'(tick_miss), 0);
            check("dis_x", int'(x_pos), mx);
        end
        enable = 1'b1;

        do_spawn(620, 460);
        for (int i = 0; i < 10; i++) tick_step(1, 0, 1, 0);
        check("r039_x", int'(x_pos), WRAP ? 5 : 624);
        check("r039_y", int'(y_pos), WRAP ? 5 : 464);

        do_spawn(1000, 500);

        // spawn and tick together: load wins, no step, no miss
        spawn_x   = XB'(10);
        spawn_y   = YB'(20);
        spawn_req = 1'b1;
        set_dirs(1, 0, 1, 0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("prio_ack", int'(spawn_ack), 1);
        check("prio_miss", int'(tick_miss), 0);
        spawn_req = 1'b0;
        @(negedge clk);
        check("prio_ack_low", int'(spawn_ack), 0);
        check("prio_miss2", int'(tick_miss), 0);
        check("prio_busy", int'(busy), 0);
        check("prio_x", int'(x_pos), 10);
        check("prio_y", int'(y_pos), 20);
        mx = 10;
        my = 20;
        @(negedge clk);
        check("prio_nostep", int'(x_pos), 10);

        // spawn raised during STEP_X waits for the step to finish
        e.x = step(mx, 1, 0, XM);
        e.y = step(my, 1, 0, YM);
        tick = 1'b1;
        @(negedge clk);
        tick      = 1'b0;
        spawn_x   = XB'(100);
        spawn_y   = YB'(50);
        spawn_req = 1'b1;
        @(negedge clk);
        check("pend_x", int'(x_pos), e.x);
        check("pend_ack0", int'(spawn_ack), 0);
        @(negedge clk);
        check("pend_y", int'(y_pos), e.y);
        check("pend_ack1", int'(spawn_ack), 0);
        @(negedge clk);
        check("pend_ack_3cyc", int'(spawn_ack), 1);
        spawn_req = 1'b0;
        @(negedge clk);
        check("pend_lx", int'(x_pos), 100);
        check("pend_ly", int'(y_pos), 50);
        mx = 100;
        my = 50;

        // tick during STEP_Y is dropped and flagged
        e.x = step(mx, 1, 0, XM);
        e.y = step(my, 1, 0, YM);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("miss_pulse", int'(tick_miss), 1);
        @(negedge clk);
        check("miss_clear", int'(tick_miss), 0);
        check("miss_busy", int'(busy), 0);
        check("miss_x", int'(x_pos), e.x);
        check("miss_y", int'(y_pos), e.y);
        mx = e.x;
        my = e.y;

        // enable drop in STEP_X aborts with no update
        tick = 1'b1;
        @(negedge clk);
        tick   = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_x", int'(x_pos), mx);
        enable = 1'b1;
        @(negedge clk);
        check("abort_y", int'(y_pos), my);

        // async reset in STEP_X with a spawn pending
        tick = 1'b1;
        @(negedge clk);
        tick      = 1'b0;
        spawn_req = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_x", int'(x_pos), 0);
        check("arst_y", int'(y_pos), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ack", int'(spawn_ack), 0);
        spawn_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mx = 0;
        my = 0;
        tick_step(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_noack", int'(spawn_ack), 0);
        end
        tick_step(0, 1, 0, 1);

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_move_ctrl.md
SPRITE_MOVE_CTRL -- requirements
Module: sprite_move_ctrl

Interface
REQ-001 Parameter X_BITS, default 10: width of X position.
REQ-002 Parameter Y_BITS, default 10: width of Y position.
REQ-003 Parameter X_MAX, default 624: largest legal X position; must fit in X_BITS.
REQ-004 Parameter Y_MAX, default 464: largest legal Y position; must fit in Y_BITS.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high allows movement; low freezes position; spawn is still serviced.
REQ-008 tick  input  1  one-cycle movement-rate pulse, e.g. a frame tick.
REQ-009 dir_up, dir_down, dir_left, dir_right  input  1 each  joystick direction levels, already synchronized.
REQ-010 spawn_req  input  1  request to load the spawn position; held high until spawn_ack.
REQ-011 spawn_x  input  X_BITS  spawn X coordinate.
REQ-012 spawn_y  input  Y_BITS  spawn Y coordinate.
REQ-013 spawn_ack  output  1  one-cycle pulse; spawn load completed.
REQ-014 x_pos  output  X_BITS  current sprite X, registered.
REQ-015 y_pos  output  Y_BITS  current sprite Y, registered.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.
REQ-017 tick_miss  output  1  one-cycle pulse; a tick was dropped because the FSM was not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, STEP_X, STEP_Y and LOAD, encoded in registers.
REQ-019 In IDLE, spawn_req=1 SHALL go to LOAD; it takes priority over a simultaneous tick.
REQ-020 In IDLE, with spawn_req=0, tick=1 and enable=1, the FSM SHALL go to STEP_X.
REQ-021 In IDLE, tick with enable=0 SHALL be ignored: no state change and no tick_miss.
REQ-022 STEP_X SHALL update x_pos once and then go to STEP_Y; STEP_Y SHALL update y_pos once and then go to IDLE.
REQ-023 x_pos SHALL change on the edge ending STEP_X (tick +2 edges); y_pos SHALL change on the edge ending STEP_Y (tick +3 edges).
REQ-024 X step: dir_right only = +1; dir_left only = -1; both or neither = hold. Directions are sampled in STEP_X.
REQ-025 Y step: dir_down only = +1; dir_up only = -1; both or neither = hold. Directions are sampled in STEP_Y.
REQ-026 Boundaries: -1 at 0 SHALL hold at 0; +1 at X_MAX or Y_MAX SHALL hold at the max (clamp, unless REQ-036 applies).
REQ-027 LOAD SHALL set x_pos=min(spawn_x,X_MAX) and y_pos=min(spawn_y,Y_MAX), pulse spawn_ack for that one cycle, then go to IDLE.
REQ-028 spawn_req raised during STEP_X or STEP_Y SHALL stay pending and be serviced from IDLE after the step sequence completes; it is never lost.
REQ-029 A tick arriving in STEP_X, STEP_Y or LOAD SHALL be dropped and SHALL pulse tick_miss on the following cycle.
REQ-030 enable falling during STEP_X or STEP_Y SHALL abort the sequence: return to IDLE next edge, with no further position update.
REQ-031 Position arithmetic SHALL be width-exact; no intermediate overflow may reach x_pos or y_pos.

Reset
REQ-032 Reset SHALL force state=IDLE, x_pos=0, y_pos=0, spawn_ack=0, busy=0 and tick_miss=0 immediately, without waiting for clk.
REQ-033 Reset asserted mid-sequence SHALL discard any pending spawn and any in-progress step.
REQ-034 The first tick or spawn SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-035 Macro SPRITE_WRAP_EN SHALL select the boundary behaviour.
REQ-036 With SPRITE_WRAP_EN defined: +1 at X_MAX gives 0; -1 at 0 gives X_MAX; the same applies on Y with Y_MAX.
REQ-037 Without SPRITE_WRAP_EN: clamping per REQ-026; the wrap logic SHALL be absent from the RTL.

Verification
REQ-038 Reset, then hold dir_right=1 and pulse tick 3 times, 10 cycles apart -> x_pos = 1, 2, 3 in turn; y_pos stays 0.
REQ-039 Set spawn 620,460, then dir_right=1 and dir_down=1 with 10 ticks -> x_pos=624, y_pos=464 (clamp). With SPRITE_WRAP_EN: x and y wrap to 0, then count up.
REQ-040 spawn_req and tick in the same IDLE cycle -> LOAD first, spawn_ack 1 cycle, no step; tick_miss=0 because the tick was consumed by priority, not dropped.
REQ-041 Tick, then spawn_req raised in STEP_X -> x and y step completes, LOAD follows, spawn_ack pulses 3 cycles after the tick edge.
REQ-042 Tick during STEP_Y -> tick_miss pulses once, position steps once only. Reset in STEP_X -> x_pos=0, y_pos=0 immediately, no spawn_ack.
REQ-043 dir_left and dir_right both high with 4 ticks -> x_pos unchanged. enable=0 with 4 ticks -> no change, busy stays 0.
